// File: rtl/riscv_hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard.
//   REG_ADDR_W / NUM_REGS : architectural register file geometry
//   LOAD_CNT_W            : width of the outstanding-load counter
//   sb_state_e            : per-register tracking state
//   reg_onehot()          : register index to one-hot decode
package riscv_hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int LOAD_CNT_W = 3;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_ALU_PEND  = 2'd1,
    SB_LOAD_PEND = 2'd2
  } sb_state_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/riscv_hazard_scoreboard_entry.sv
// Tracking state for a single architectural register.
//   i_set_alu  : an ALU instruction writing this register issues
//   i_set_load : a load writing this register issues
//   i_clr      : the pending result completes this cycle (already qualified by the top)
//   i_flush    : pipeline flush; drops ALU work, loads keep draining
//   o_state    : current state (sb_state_e encoding)
//   o_busy     : state != FREE
//
// state        | meaning
// SB_FREE      | no in-flight writer, value is architectural
// SB_ALU_PEND  | ALU result in flight, forwardable from WB
// SB_LOAD_PEND | load data outstanding from data memory
module riscv_hazard_scoreboard_entry
  import riscv_hazard_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_set_alu,
  input  logic       i_set_load,
  input  logic       i_clr,
  input  logic       i_flush,
  output logic [1:0] o_state,
  output logic       o_busy
);

  sb_state_e r_state;
  sb_state_e w_state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SB_FREE;
    else          r_state <= w_state_nxt;
  end

  // A new issue overrides a completion of the previous writer in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (i_set_load) begin
      w_state_nxt = SB_LOAD_PEND;
    end else if (i_set_alu) begin
      w_state_nxt = SB_ALU_PEND;
    end else begin
      case (r_state)
        SB_ALU_PEND:  if (i_clr || i_flush) w_state_nxt = SB_FREE;
        SB_LOAD_PEND: if (i_clr)            w_state_nxt = SB_FREE;
        default:                            w_state_nxt = SB_FREE;
      endcase
    end
  end

  always_comb begin
    o_state = r_state;
    o_busy  = (r_state != SB_FREE);
  end

endmodule

// File: rtl/riscv_hazard_scoreboard.sv
// Issue-side hazard scoreboard. Tracks every in-flight destination register
// from decode to writeback and stalls decode on load-use, WAW (and, without
// forwarding, RAW on ALU results) and on the outstanding-load limit.
//   clk, reset_n                 : clock, async active-low reset
//   id_*                         : instruction currently in ID
//   flush                        : squash ALU-pending work and the ID instruction
//   WB_RegWrite / WB_rd          : ALU writeback completion
//   mem_rvalid / mem_rd          : load data completion
//   id_stall / id_issue          : combinational decode control
//   busy_vec                     : per-register pending flags (bit 0 always 0)
//   loads_out                    : outstanding load count
//   err_spurious                 : sticky, a completion hit a FREE register
// MAX_LOADS must lie in 1..7 to fit loads_out.
module riscv_hazard_scoreboard
  import riscv_hazard_scoreboard_pkg::*;
#(
  parameter int MAX_LOADS = 4,
  parameter bit FWD_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_RegWrite,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  WB_RegWrite,
  input  logic [REG_ADDR_W-1:0] WB_rd,
  input  logic                  mem_rvalid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  id_stall,
  output logic                  id_issue,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [LOAD_CNT_W-1:0] loads_out,
  output logic                  err_spurious
);

  localparam logic [LOAD_CNT_W-1:0] MAX_CNT = LOAD_CNT_W'(MAX_LOADS);

  logic [NUM_REGS-1:0][1:0] w_state;
  logic [NUM_REGS-1:0]      w_busy;
  logic [NUM_REGS-1:0]      w_is_alu;
  logic [NUM_REGS-1:0]      w_is_load;
  logic [NUM_REGS-1:0]      w_wb_oh;
  logic [NUM_REGS-1:0]      w_mem_oh;
  logic [NUM_REGS-1:0]      w_wb_done;
  logic [NUM_REGS-1:0]      w_mem_done;
  logic [NUM_REGS-1:0]      w_cmpl;
  logic [NUM_REGS-1:0]      w_pend_alu;
  logic [NUM_REGS-1:0]      w_pend_load;
  logic [NUM_REGS-1:0]      w_rd_oh;
  logic [NUM_REGS-1:0]      w_set_alu;
  logic [NUM_REGS-1:0]      w_set_load;
  logic                     w_src_load;
  logic                     w_src_alu;
  logic                     w_waw;
  logic                     w_ld_full;
  logic                     w_issue_wr;
  logic                     w_ld_inc;
  logic                     w_ld_dec;
  logic                     w_dec_at_zero;
  logic                     w_spur;
  logic [LOAD_CNT_W-1:0]    r_loads_out;
  logic                     r_err;

  // x0 is never tracked.
  assign w_state[0] = SB_FREE;
  assign w_busy[0]  = 1'b0;

  generate
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
      riscv_hazard_scoreboard_entry u_entry (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_set_alu  (w_set_alu[g]),
        .i_set_load (w_set_load[g]),
        .i_clr      (w_cmpl[g]),
        .i_flush    (flush),
        .o_state    (w_state[g]),
        .o_busy     (w_busy[g])
      );
    end
  endgenerate

  always_comb begin
    w_is_alu  = '0;
    w_is_load = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_is_alu[r]  = (w_state[r] == SB_ALU_PEND);
      w_is_load[r] = (w_state[r] == SB_LOAD_PEND);
    end
  end

  // A completion only counts when it matches the kind of work pending on
  // that register; x0 is never pending so it can never complete.
  assign w_wb_oh    = WB_RegWrite ? reg_onehot(WB_rd) : '0;
  assign w_mem_oh   = mem_rvalid ? reg_onehot(mem_rd) : '0;
  assign w_wb_done  = w_wb_oh & w_is_alu;
  assign w_mem_done = w_mem_oh & w_is_load;
  assign w_cmpl     = w_wb_done | w_mem_done;

  // Registers completing this cycle are bypassed by WB forwarding, so they
  // no longer block decode.
  assign w_pend_alu  = w_is_alu & ~w_cmpl;
  assign w_pend_load = w_is_load & ~w_cmpl;

  assign w_src_load = (id_use_rs1 & w_pend_load[id_rs1]) | (id_use_rs2 & w_pend_load[id_rs2]);
  assign w_src_alu  = (id_use_rs1 & w_pend_alu[id_rs1])  | (id_use_rs2 & w_pend_alu[id_rs2]);
  assign w_waw      = id_RegWrite & (w_pend_alu[id_rd] | w_pend_load[id_rd]);
  assign w_ld_full  = id_is_load & (r_loads_out == MAX_CNT) & ~mem_rvalid;

  assign id_stall = id_valid & (w_src_load | (~FWD_EN & w_src_alu) | w_waw | w_ld_full);
  assign id_issue = id_valid & ~id_stall & ~flush;

  assign w_issue_wr = id_issue & id_RegWrite & (id_rd != '0);
  assign w_rd_oh    = w_issue_wr ? reg_onehot(id_rd) : '0;
  assign w_set_load = id_is_load ? w_rd_oh : '0;
  assign w_set_alu  = id_is_load ? '0 : w_rd_oh;

  assign w_ld_inc      = w_issue_wr & id_is_load;
  assign w_ld_dec      = |w_mem_done;
  assign w_dec_at_zero = w_ld_dec & ~w_ld_inc & (r_loads_out == '0);

  assign w_spur = (WB_RegWrite & (WB_rd != '0) & ~w_busy[WB_rd])
                | (mem_rvalid & ~w_busy[mem_rd]);

  // The counter saturates at MAX_LOADS and never goes below 0; an
  // impossible decrement is reported through the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loads_out <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_ld_inc && !w_ld_dec) begin
        if (r_loads_out != MAX_CNT) r_loads_out <= r_loads_out + 1'b1;
      end else if (w_ld_dec && !w_ld_inc) begin
        if (r_loads_out != '0) r_loads_out <= r_loads_out - 1'b1;
      end
      if (w_spur || w_dec_at_zero) r_err <= 1'b1;
    end
  end

  assign busy_vec     = w_busy;
  assign loads_out    = r_loads_out;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
module tb_riscv_hazard_scoreboard;

  localparam int MAXL = 4;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_RegWrite;
  logic [4:0] id_rd;
  logic       id_is_load;
  logic       flush;
  logic       WB_RegWrite;
  logic [4:0] WB_rd;
  logic       mem_rvalid;
  logic [4:0] mem_rd;

  logic        stall0, issue0, err0, stall1, issue1, err1;
  logic [31:0] busy0, busy1;
  logic [2:0]  loads0, loads1;

  int errors = 0;
  int checks = 0;

  // Reference model: one copy per DUT (index 0 forwards, index 1 does not).
  // Register state: 0 free, 1 ALU result pending, 2 load pending.
  int ms [2][32];
  int ml [2];
  bit me [2];

  typedef struct {
    bit       v;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
    bit       we;
    bit [4:0] rd;
    bit       ld;
    bit       fl;
    bit       wbw;
    bit [4:0] wbrd;
    bit       mv;
    bit [4:0] mrd;
  } in_t;

  typedef struct {
    in_t         i;
    bit          e_stall;
    bit          e_issue;
    bit          e_stall_nf;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl [12];

  riscv_hazard_scoreboard #(.MAX_LOADS(MAXL), .FWD_EN(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_RegWrite(id_RegWrite), .id_rd(id_rd),
    .id_is_load(id_is_load), .flush(flush), .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd),
    .mem_rvalid(mem_rvalid), .mem_rd(mem_rd), .id_stall(stall0), .id_issue(issue0),
    .busy_vec(busy0), .loads_out(loads0), .err_spurious(err0)
  );

  riscv_hazard_scoreboard #(.MAX_LOADS(MAXL), .FWD_EN(1'b0)) u_dut_nf (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_RegWrite(id_RegWrite), .id_rd(id_rd),
    .id_is_load(id_is_load), .flush(flush), .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd),
    .mem_rvalid(mem_rvalid), .mem_rd(mem_rd), .id_stall(stall1), .id_issue(issue1),
    .busy_vec(busy1), .loads_out(loads1), .err_spurious(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(bit v, bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2, bit we,
                             bit [4:0] rd, bit ld, bit fl, bit wbw, bit [4:0] wbrd,
                             bit mv, bit [4:0] mrd);
    in_t x;
    x.v = v; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2; x.we = we; x.rd = rd;
    x.ld = ld; x.fl = fl; x.wbw = wbw; x.wbrd = wbrd; x.mv = mv; x.mrd = mrd;
    return x;
  endfunction

  task automatic apply(input in_t x);
    id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2; id_use_rs1 = x.u1; id_use_rs2 = x.u2;
    id_RegWrite = x.we; id_rd = x.rd; id_is_load = x.ld; flush = x.fl;
    WB_RegWrite = x.wbw; WB_rd = x.wbrd; mem_rvalid = x.mv; mem_rd = x.mrd;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // ---------------- reference model ----------------
  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) ms[k][r] = 0;
      ml[k] = 0;
      me[k] = 1'b0;
    end
  endfunction

  function automatic bit m_done(int k, int r);
    if (r == 0) return 1'b0;
    return (WB_RegWrite && int'(WB_rd) == r && ms[k][r] == 1) ||
           (mem_rvalid && int'(mem_rd) == r && ms[k][r] == 2);
  endfunction

  // Register still blocks decode: pending (of the given kind, 0 = any) and not completing now.
  function automatic bit m_wait(int k, int r, int kind);
    if (r == 0 || ms[k][r] == 0 || m_done(k, r)) return 1'b0;
    return (kind == 0) || (ms[k][r] == kind);
  endfunction

  function automatic bit m_stall(int k);
    bit s;
    s = (id_use_rs1 && m_wait(k, int'(id_rs1), 2)) || (id_use_rs2 && m_wait(k, int'(id_rs2), 2));
    if (k == 1)
      s = s || (id_use_rs1 && m_wait(k, int'(id_rs1), 1)) || (id_use_rs2 && m_wait(k, int'(id_rs2), 1));
    s = s || (id_RegWrite && m_wait(k, int'(id_rd), 0));
    s = s || (id_is_load && ml[k] == MAXL && !mem_rvalid);
    return id_valid && s;
  endfunction

  function automatic bit m_issue(int k);
    return id_valid && !m_stall(k) && !flush;
  endfunction

  function automatic logic [31:0] m_busy(int k);
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (ms[k][r] != 0);
    return b;
  endfunction

  function automatic void m_edge(int k);
    int ns [32];
    bit iss;
    iss = m_issue(k);
    for (int r = 0; r < 32; r++) ns[r] = ms[k][r];
    if (WB_RegWrite && WB_rd != 0) begin
      if (ms[k][WB_rd] == 1) ns[WB_rd] = 0;
      else if (ms[k][WB_rd] == 0) me[k] = 1'b1;
    end
    if (mem_rvalid) begin
      if (ms[k][mem_rd] == 2) begin
        ns[mem_rd] = 0;
        if (ml[k] == 0) me[k] = 1'b1;
        else ml[k] = ml[k] - 1;
      end else if (ms[k][mem_rd] == 0) begin
        me[k] = 1'b1;
      end
    end
    if (flush)
      for (int r = 0; r < 32; r++) if (ms[k][r] == 1) ns[r] = 0;
    if (iss && id_RegWrite && id_rd != 0) begin
      ns[id_rd] = id_is_load ? 2 : 1;
      if (id_is_load && ml[k] < MAXL) ml[k] = ml[k] + 1;
    end
    for (int r = 0; r < 32; r++) ms[k][r] = ns[r];
  endfunction

  task automatic check_all();
    chk("stall_fwd",  32'(stall0), 32'(m_stall(0)));
    chk("issue_fwd",  32'(issue0), 32'(m_issue(0)));
    chk("busy_fwd",   busy0,       m_busy(0));
    chk("loads_fwd",  32'(loads0), 32'(ml[0]));
    chk("err_fwd",    32'(err0),   32'(me[0]));
    chk("stall_nfwd", 32'(stall1), 32'(m_stall(1)));
    chk("issue_nfwd", 32'(issue1), 32'(m_issue(1)));
    chk("busy_nfwd",  busy1,       m_busy(1));
    chk("loads_nfwd", 32'(loads1), 32'(ml[1]));
    chk("err_nfwd",   32'(err1),   32'(me[1]));
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_all();
  endtask

  task automatic to_pos();
    m_edge(0);
    m_edge(1);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input in_t x);
    apply(x);
    at_neg();
    to_pos();
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    idle();
    #1;
    m_reset();
    chk("rst_busy",  busy0,       32'h0);
    chk("rst_loads", 32'(loads0), 32'h0);
    chk("rst_err",   32'(err0),   32'h0);
    chk("rst_busy_nf", busy1,     32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",  busy0,       32'h0);
    chk("reset_loads", 32'(loads0), 32'h0);
    chk("reset_err",   32'(err0),   32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use then ALU forwarding scenarios; expected values from reset state.
    tbl[0]  = '{mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{mk(1, 5, 1, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b1, 32'h20};
    tbl[2]  = '{mk(1, 5, 1, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b1, 32'h20};
    tbl[3]  = '{mk(1, 5, 1, 1, 1, 1, 6, 0, 0, 0, 0, 1, 5), 1'b0, 1'b1, 1'b0, 32'h20};
    tbl[4]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 32'h40};
    tbl[5]  = '{mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 32'h40};
    tbl[6]  = '{mk(1, 7, 0, 1, 0, 1, 8, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b1, 32'hC0};
    tbl[7]  = '{mk(1, 7, 0, 1, 0, 1, 8, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b1, 32'h1C0};
    tbl[8]  = '{mk(1, 7, 0, 1, 0, 1, 8, 0, 0, 1, 7, 0, 0), 1'b1, 1'b0, 1'b0, 32'h1C0};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0), 1'b0, 1'b0, 1'b0, 32'h140};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0), 1'b0, 1'b0, 1'b0, 32'h100};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].i);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i),    32'(stall0), 32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_issue", i),    32'(issue0), 32'(tbl[i].e_issue));
      chk($sformatf("tbl%0d_stall_nf", i), 32'(stall1), 32'(tbl[i].e_stall_nf));
      chk($sformatf("tbl%0d_busy", i),     busy0,       tbl[i].e_busy);
      check_all();
      to_pos();
    end

    // Load limit.
    for (int i = 1; i <= 4; i++) cyc(mk(1, 0, 0, 0, 0, 1, 5'(i), 1, 0, 0, 0, 0, 0));
    chk("limit_loads4", 32'(loads0), 32'd4);
    apply(mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0));
    at_neg();
    chk("limit_stall", 32'(stall0), 32'd1);
    to_pos();
    apply(mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 1, 1));
    at_neg();
    chk("limit_issue_on_rvalid", 32'(issue0), 32'd1);
    to_pos();
    chk("limit_loads_hold", 32'(loads0), 32'd4);
    chk("limit_busy", busy0, 32'h41C);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10));
    chk("limit_drained", 32'(loads0), 32'd0);

    // Flush.
    cyc(mk(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0));
    cyc(mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 1, 11, 0, 1, 0, 0, 0, 0));
    at_neg();
    chk("flush_issue", 32'(issue0), 32'd0);
    to_pos();
    chk("flush_busy", busy0, 32'h200);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9));
    chk("flush_drain_busy", busy0,      32'h0);
    chk("flush_drain_err",  32'(err0),  32'd0);

    // x0 destination and spurious completion.
    apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    at_neg();
    chk("x0_issue", 32'(issue0), 32'd1);
    to_pos();
    chk("x0_busy", busy0, 32'h0);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0));
    chk("spur_set", 32'(err0), 32'd1);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("spur_held", 32'(err0), 32'd1);

    // Async reset mid-run with loads pending.
    async_reset();
    for (int i = 1; i <= 3; i++) cyc(mk(1, 0, 0, 0, 0, 1, 5'(i), 1, 0, 0, 0, 0, 0));
    chk("rst_pre_loads", 32'(loads0), 32'd3);
    async_reset();
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    chk("rst_late_spur", 32'(err0),   32'd1);
    chk("rst_late_loads", 32'(loads0), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 0) async_reset();
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_use_rs1  = ($urandom_range(0, 1) == 1);
      id_use_rs2  = ($urandom_range(0, 1) == 1);
      id_RegWrite = ($urandom_range(0, 4) != 0);
      id_rd       = 5'($urandom_range(0, 7));
      id_is_load  = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      WB_rd       = 5'($urandom_range(0, 7));
      WB_RegWrite = (ms[0][WB_rd] == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      mem_rd      = 5'($urandom_range(1, 7));
      mem_rvalid  = (ms[0][mem_rd] == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      if (mem_rd == WB_rd) mem_rvalid = 1'b0;
      at_neg();
      to_pos();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
